rll_key_loader: RTL and testbench

- Upstream stage of the 32-bit RLL-locked combinational benchmarks. Feeds their keyIn_0_0..keyIn_0_31 inputs.
- Receives the secret key as a bit-serial stream with a valid/ready handshake, followed by an XOR-fold checksum.
- Verifies the checksum, then commits the key to a held parallel register that drives the locked netlist.
- Supports restart and zeroize; never exposes a partially loaded or unverified key.

---
 rtl/rll_key_pkg.sv | 28 ++
 rtl/rll_key_chk_fold.sv | 36 +++
 rtl/rll_key_loader.sv | 149 ++++++++++++++
 tb/tb_rll_key_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_key_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rll_key_pkg
// Purpose : Shared types and constants for the RLL key loader.
//           - state_t     : loader FSM states
//           - *_DEF       : default key / checksum widths
//           - num_slices  : number of checksum-wide slices folded from a key
// Revision: 1.0 - initial release
// ============================================================================
package rll_key_pkg;

  localparam int KEY_WIDTH_DEF  = 32;
  localparam int CHK_WIDTH_DEF  = 8;
  localparam int NUM_SLICES_DEF = KEY_WIDTH_DEF / CHK_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEY    = 2'd1,
    CHK    = 2'd2,
    VERIFY = 2'd3
  } state_t;

  function automatic int num_slices(input int key_width, input int chk_width);
    return key_width / chk_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rll_key_chk_fold.sv
`default_nettype none
// ============================================================================
// Module  : rll_key_chk_fold
// Purpose : XOR-fold of a key into one checksum-wide word (combinational).
// Ports   : key  in  KEY_WIDTH  key to fold
//           fold out CHK_WIDTH  XOR of all CHK_WIDTH-bit slices of key
// Revision: 1.0 - initial release
// ============================================================================
module rll_key_chk_fold
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int CHK_WIDTH = CHK_WIDTH_DEF
) (
  input  logic [KEY_WIDTH-1:0] key,
  output logic [CHK_WIDTH-1:0] fold
);

  localparam int NUM_SLICES = num_slices(KEY_WIDTH, CHK_WIDTH);

  // The fold only makes sense when the key splits into whole slices.
  generate
    if ((KEY_WIDTH % CHK_WIDTH) != 0) begin : g_width_check
      $error("rll_key_chk_fold: KEY_WIDTH must be a multiple of CHK_WIDTH");
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      fold = fold ^ key[s*CHK_WIDTH +: CHK_WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rll_key_loader.sv
`default_nettype none
// ============================================================================
// Module  : rll_key_loader
// Purpose : Bit-serial key loader for RLL-locked netlists. Shifts in a key
//           (LSB first) and its XOR-fold checksum, verifies, then commits the
//           key to a held parallel register.
// Ports   : clk         in   clock, all state on rising edge
//           rst_n       in   synchronous active-low reset
//           load_start  in   pulse, begins/restarts a load
//           zeroize     in   level, clears all key material
//           key_valid   in   serial bit valid
//           key_bit     in   serial bit (key bits, then checksum bits)
//           key_ready   out  loader accepts serial bits
//           key_out     out  committed key (bit i drives keyIn_0_i)
//           key_loaded  out  key_out holds a verified key
//           key_err     out  sticky, last load failed checksum
// Revision: 1.0 - initial release
// ============================================================================
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int CHK_WIDTH = CHK_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 zeroize,
  input  logic                 key_valid,
  input  logic                 key_bit,
  output logic                 key_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_loaded,
  output logic                 key_err
);

  // One counter serves both phases; it is sized for the longer key phase.
  localparam int CNT_W     = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam int CHK_IDX_W = (CHK_WIDTH > 1) ? $clog2(CHK_WIDTH) : 1;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WIDTH - 1);
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHK_WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CHK_WIDTH-1:0] chk_reg;
  logic [CNT_W-1:0]     cnt;
  logic [CHK_WIDTH-1:0] fold;
  logic                 xfer;

  rll_key_chk_fold #(
    .KEY_WIDTH (KEY_WIDTH),
    .CHK_WIDTH (CHK_WIDTH)
  ) u_fold (
    .key  (shadow),
    .fold (fold)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake
  always_comb begin
    state_nxt = state;
    key_ready = (state == KEY) || (state == CHK);
    xfer      = key_valid && key_ready;
    if (zeroize) begin
      state_nxt = IDLE;
    end else if (load_start) begin
      // Start from IDLE and restart from any other state look the same.
      state_nxt = KEY;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        KEY:     if (xfer && (cnt == KEY_LAST)) state_nxt = CHK;
        CHK:     if (xfer && (cnt == CHK_LAST)) state_nxt = VERIFY;
        VERIFY:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Key material and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow     <= '0;
      chk_reg    <= '0;
      cnt        <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else if (zeroize) begin
      shadow     <= '0;
      chk_reg    <= '0;
      cnt        <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else if (load_start) begin
      // A bit presented alongside load_start is dropped on purpose.
      shadow     <= '0;
      chk_reg    <= '0;
      cnt        <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shadow  <= '0;
          chk_reg <= '0;
          cnt     <= '0;
        end
        KEY: begin
          if (xfer) begin
            shadow[cnt] <= key_bit;
            cnt         <= (cnt == KEY_LAST) ? '0 : cnt + 1'b1;
          end
        end
        CHK: begin
          if (xfer) begin
            chk_reg[cnt[CHK_IDX_W-1:0]] <= key_bit;
            cnt                         <= cnt + 1'b1;
          end
        end
        VERIFY: begin
          cnt <= '0;
          if (fold == chk_reg) begin
            key_out    <= shadow;
            key_loaded <= 1'b1;
          end else begin
            key_err <= 1'b1;
            shadow  <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rll_key_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_rll_key_loader
// Purpose : Self-checking bench for rll_key_loader. Each completed load
//           pushes its expected outcome to a scoreboard; a monitor pops and
//           compares whenever key_loaded or key_err rises.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        zeroize;
  logic        key_valid;
  logic        key_bit;
  logic        key_ready;
  logic [31:0] key_out;
  logic        key_loaded;
  logic        key_err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] key;
    logic        loaded;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  exp_t want_e;
  logic prev_loaded = 1'b0;
  logic prev_err    = 1'b0;

  always #5 clk = ~clk;

  rll_key_loader #(.KEY_WIDTH(32), .CHK_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .zeroize    (zeroize),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_loaded (key_loaded),
    .key_err    (key_err)
  );

  // Reference checksum written out slice by slice.
  function automatic logic [7:0] ref_fold(input logic [31:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
  endfunction

  // Scoreboard monitor: every outcome edge must match the oldest expectation.
  always @(negedge clk) begin
    if ((key_loaded && !prev_loaded) || (key_err && !prev_err)) begin
      tests++;
      got_e = '{key: key_out, loaded: key_loaded, err: key_err};
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got key=%h loaded=%b err=%b, required no outcome",
                 key_out, key_loaded, key_err);
      end else begin
        want_e = sb.pop_front();
        if (got_e !== want_e) begin
          fails++;
          $display("FAIL sb_outcome: got key=%h loaded=%b err=%b, required key=%h loaded=%b err=%b",
                   got_e.key, got_e.loaded, got_e.err, want_e.key, want_e.loaded, want_e.err);
        end
      end
    end
    prev_loaded = key_loaded;
    prev_err    = key_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Drives data[first..last], one bit per cycle (or every other cycle when
  // gaps is set). key_ready is checked before each bit is presented.
  task automatic drive_bits(input logic [39:0] data, input int first, input int last,
                            input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        @(negedge clk);
        load_start = 1'b0;
        key_valid  = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (key_ready !== 1'b1) begin
        fails++;
        $display("FAIL ready_bit%0d: got %b, required 1", i, key_ready);
      end
      load_start = 1'b0;
      key_valid  = 1'b1;
      key_bit    = data[i];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    key_valid  = 1'b0;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    load_start = 1'b0;
    key_valid  = 1'b0;
    key_bit    = 1'b0;
    zeroize    = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_start = 1'b0; zeroize = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full load, checked for the cycle-41 VERIFY / cycle-42 commit timing.
  task automatic full_load(input string name, input logic [31:0] key, input logic [7:0] chk,
                           input bit gaps, input logic [31:0] key_before);
    pulse_start();
    drive_bits({chk, key}, 0, 39, gaps);
    idle_inputs();                       // VERIFY cycle
    chk1({name, "_verify_ready"}, key_ready, 1'b0);
    chk1({name, "_verify_loaded"}, key_loaded, 1'b0);
    chk32({name, "_verify_keyout"}, key_out, key_before);
    @(negedge clk);                      // outcome visible
  endtask

  task automatic test_reset();
    apply_reset();
    chk32("reset_key_out", key_out, 32'h0);
    chk1("reset_loaded", key_loaded, 1'b0);
    chk1("reset_err", key_err, 1'b0);
    chk1("reset_ready", key_ready, 1'b0);
  endtask

  task automatic test_good_load();
    sb.push_back('{key: 32'h12345678, loaded: 1'b1, err: 1'b0});
    full_load("good", 32'h12345678, 8'h08, 1'b0, 32'h0);
    chk32("good_key_out", key_out, 32'h12345678);
    chk1("good_loaded", key_loaded, 1'b1);
    chk1("good_err", key_err, 1'b0);
    @(negedge clk);
    chk1("good_loaded_held", key_loaded, 1'b1);
  endtask

  task automatic test_bad_chk();
    apply_reset();
    sb.push_back('{key: 32'h0, loaded: 1'b0, err: 1'b1});
    full_load("badchk", 32'h12345678, 8'h09, 1'b0, 32'h0);
    chk1("badchk_err", key_err, 1'b1);
    chk1("badchk_loaded", key_loaded, 1'b0);
    chk32("badchk_key_out", key_out, 32'h0);
    @(negedge clk);
    chk1("badchk_err_sticky", key_err, 1'b1);
  endtask

  task automatic test_gaps();
    sb.push_back('{key: 32'h12345678, loaded: 1'b1, err: 1'b0});
    full_load("gaps", 32'h12345678, ref_fold(32'h12345678), 1'b1, 32'h0);
    chk32("gaps_key_out", key_out, 32'h12345678);
    chk1("gaps_loaded", key_loaded, 1'b1);
    chk1("gaps_err", key_err, 1'b0);
  endtask

  task automatic test_restart();
    logic [31:0] k2;
    k2 = 32'hCAFEF00D;
    pulse_start();
    drive_bits({8'h00, 32'hFFFF_FFFF}, 0, 19, 1'b0);
    // Restart with a bit in the same cycle; that bit must be dropped.
    @(negedge clk);
    load_start = 1'b1;
    key_valid  = 1'b1;
    key_bit    = 1'b1;
    chk32("restart_key_out_mid", key_out, 32'h12345678);
    chk1("restart_loaded_cleared", key_loaded, 1'b0);
    sb.push_back('{key: k2, loaded: 1'b1, err: 1'b0});
    drive_bits({ref_fold(k2), k2}, 0, 39, 1'b0);
    idle_inputs();
    chk32("restart_key_out_verify", key_out, 32'h12345678);
    @(negedge clk);
    chk32("restart_key_out_commit", key_out, k2);
    chk1("restart_loaded", key_loaded, 1'b1);
  endtask

  task automatic test_zeroize();
    logic [31:0] k3;
    k3 = 32'h0BADF00D;
    pulse_start();
    drive_bits({ref_fold(k3), k3}, 0, 38, 1'b0);
    @(negedge clk);
    key_valid = 1'b1;
    key_bit   = ref_fold(k3)[7];
    zeroize   = 1'b1;
    @(negedge clk);
    chk32("zero_key_out", key_out, 32'h0);
    chk1("zero_loaded", key_loaded, 1'b0);
    chk1("zero_err", key_err, 1'b0);
    chk1("zero_ready", key_ready, 1'b0);
    // Held zeroize beats load_start.
    load_start = 1'b1;
    key_valid  = 1'b0;
    @(negedge clk);
    chk1("zero_hold_ready", key_ready, 1'b0);
    idle_inputs();
    @(negedge clk);
    chk1("zero_release_ready", key_ready, 1'b0);
    chk1("zero_release_loaded", key_loaded, 1'b0);
  endtask

  task automatic test_reset_mid_key();
    sb.push_back('{key: 32'h12345678, loaded: 1'b1, err: 1'b0});
    full_load("pre_rst", 32'h12345678, 8'h08, 1'b0, 32'h0);
    chk32("pre_rst_key_out", key_out, 32'h12345678);
    pulse_start();
    drive_bits(40'hFF_A5A5A5A5, 0, 9, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk32("midrst_key_out", key_out, 32'h0);
    chk1("midrst_loaded", key_loaded, 1'b0);
    chk1("midrst_err", key_err, 1'b0);
    chk1("midrst_ready", key_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      key_bit = i[0];
      @(negedge clk);
      chk1("midrst_ignore_ready", key_ready, 1'b0);
    end
    idle_inputs();
    chk32("midrst_key_out_after", key_out, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    zeroize    = 1'b0;
    key_valid  = 1'b0;
    key_bit    = 1'b0;

    test_reset();
    test_good_load();
    test_bad_chk();
    test_gaps();
    test_restart();
    test_zeroize();
    test_reset_mid_key();

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending outcomes, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
